// File: rtl/stats_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : stats_sequencer_if
//  Purpose  : Cache-event inputs, control requests and snapshot outputs of the
//             statistics sequencer, with master (driver) and slave (sequencer) views.
//  Revision : 1.0  initial release
// ============================================================================
interface stats_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             i_evt;
  logic             i_hit;
  logic             d_evt;
  logic             d_write;
  logic             d_hit;
  logic             clear_req;
  logic             print_req;
  logic [CNT_W-1:0] ins_reads;
  logic [CNT_W-1:0] ins_hit;
  logic [CNT_W-1:0] ins_miss;
  logic [CNT_W-1:0] data_reads;
  logic [CNT_W-1:0] data_writes;
  logic [CNT_W-1:0] data_hit;
  logic [CNT_W-1:0] data_miss;
  logic             print;
  logic             busy;

  modport master (
    output i_evt, i_hit, d_evt, d_write, d_hit, clear_req, print_req,
    input  ins_reads, ins_hit, ins_miss, data_reads, data_writes, data_hit, data_miss,
    input  print, busy
  );

  modport slave (
    input  i_evt, i_hit, d_evt, d_write, d_hit, clear_req, print_req,
    output ins_reads, ins_hit, ins_miss, data_reads, data_writes, data_hit, data_miss,
    output print, busy
  );
endinterface
`default_nettype wire

// File: rtl/stats_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : stats_sequencer
//  Purpose  : Saturating cache-access counters with a snapshot/print sequencer
//             feeding a statistics print block.
//  Revision : 1.0  initial release
// ============================================================================
module stats_sequencer #(
  parameter int CNT_W      = 32,
  parameter int PRINT_HOLD = 2
) (
  input  logic             clk,
  input  logic             reset,
  stats_sequencer_if.slave bus
);

  localparam int               c_N         = 7;
  localparam logic [CNT_W-1:0] c_MAX       = '1;
  localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);
  localparam logic [3:0]       c_HOLD_LAST = 4'(PRINT_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SNAP  = 2'd1,
    PRINT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_hold;
  logic [3:0]       w_hold_nxt;
  logic             r_pending;
  logic             w_pending_nxt;
  logic             r_early;
  logic             w_snap_early;
  logic             w_snap_late;
  logic             r_print;
  logic             r_busy;

  logic [c_N-1:0]   w_inc;
  logic [CNT_W-1:0] r_cnt     [c_N];
  logic [CNT_W-1:0] w_cnt_add [c_N];
  logic [CNT_W-1:0] r_snap    [c_N];

  // Bit order: ins_reads, ins_hit, ins_miss, data_reads, data_writes, data_hit, data_miss
  assign w_inc = { bus.d_evt & ~bus.d_hit,
                   bus.d_evt &  bus.d_hit,
                   bus.d_evt &  bus.d_write,
                   bus.d_evt & ~bus.d_write,
                   bus.i_evt & ~bus.i_hit,
                   bus.i_evt &  bus.i_hit,
                   bus.i_evt };

  always_comb begin
    for (int k = 0; k < c_N; k++) begin
      w_cnt_add[k] = (w_inc[k] && (r_cnt[k] != c_MAX)) ? r_cnt[k] + c_ONE : r_cnt[k];
    end
  end

  // A clear coinciding with the start of a print captures the pre-clear counts
  // one edge early; the SNAP load is then skipped so those values survive.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < c_N; k++) begin
        r_cnt[k]  <= '0;
        r_snap[k] <= '0;
      end
    end else begin
      for (int k = 0; k < c_N; k++) begin
        r_cnt[k] <= bus.clear_req ? (w_inc[k] ? c_ONE : '0) : w_cnt_add[k];
        if (w_snap_early) begin
          r_snap[k] <= r_cnt[k];
        end else if (w_snap_late) begin
          r_snap[k] <= w_cnt_add[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_hold    <= '0;
      r_pending <= 1'b0;
      r_early   <= 1'b0;
      r_print   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hold    <= w_hold_nxt;
      r_pending <= w_pending_nxt;
      r_early   <= w_snap_early;
      r_print   <= (w_state_nxt == PRINT);
      r_busy    <= (w_state_nxt != IDLE);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold;
    w_pending_nxt = r_pending | bus.print_req;
    w_snap_early  = 1'b0;
    w_snap_late   = 1'b0;
    case (r_state)
      IDLE: begin
        w_pending_nxt = 1'b0;
        if (bus.print_req || r_pending) begin
          w_state_nxt  = SNAP;
          w_snap_early = bus.clear_req;
        end
      end
      SNAP: begin
        w_state_nxt = PRINT;
        w_hold_nxt  = '0;
        w_snap_late = ~r_early;
      end
      PRINT: begin
        if (r_hold == c_HOLD_LAST) begin
          w_state_nxt = GAP;
        end else begin
          w_hold_nxt = r_hold + 4'd1;
        end
      end
      GAP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.ins_reads   = r_snap[0];
  assign bus.ins_hit     = r_snap[1];
  assign bus.ins_miss    = r_snap[2];
  assign bus.data_reads  = r_snap[3];
  assign bus.data_writes = r_snap[4];
  assign bus.data_hit    = r_snap[5];
  assign bus.data_miss   = r_snap[6];
  assign bus.print       = r_print;
  assign bus.busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_stats_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stats_sequencer
//  Purpose  : Directed and random stimulus for stats_sequencer, checked against
//             an event-count / print-timeline model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stats_sequencer;
  localparam int     CW   = 32;
  localparam int     H    = 2;
  localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  logic rst4;
  always #5 clk = ~clk;

  stats_sequencer_if #(.CNT_W(CW)) bus ();
  stats_sequencer_if #(.CNT_W(4))  bus4 ();

  stats_sequencer #(.CNT_W(CW), .PRINT_HOLD(H)) dut  (.clk(clk), .reset(rst),  .bus(bus));
  stats_sequencer #(.CNT_W(4),  .PRINT_HOLD(H)) dut4 (.clk(clk), .reset(rst4), .bus(bus4));

  int n_checks = 0;
  int n_fail   = 0;

  // Model: live counts, print snapshot and position within a print job
  // (-1 idle, 0 snapshot cycle, 1..H print high, H+1 gap).
  longint m_live [7];
  longint m_snap [7];
  longint n_live [7];
  longint n_snap [7];
  int     m_j = -1, n_j = -1;
  bit     m_pend = 0, n_pend = 0, m_frozen = 0, n_frozen = 0;
  bit     m_valid = 0;

  int     rises = 0;
  longint rise_vals [$];
  logic   prev_print = 1'b0;

  string names [7] = '{"ins_reads", "ins_hit", "ins_miss", "data_reads",
                       "data_writes", "data_hit", "data_miss"};

  function automatic longint sat(longint v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  function automatic logic [63:0] dsnap(int k);
    case (k)
      0:       return 64'(bus.ins_reads);
      1:       return 64'(bus.ins_hit);
      2:       return 64'(bus.ins_miss);
      3:       return 64'(bus.data_reads);
      4:       return 64'(bus.data_writes);
      5:       return 64'(bus.data_hit);
      default: return 64'(bus.data_miss);
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk7(string tag, longint e0, longint e1, longint e2, longint e3,
                      longint e4, longint e5, longint e6);
    longint e [7];
    e = '{e0, e1, e2, e3, e4, e5, e6};
    for (int k = 0; k < 7; k++) chk({tag, "_", names[k]}, dsnap(k), e[k]);
  endtask

  task automatic model_compute();
    longint inc [7];
    inc[0] = longint'(bus.i_evt);
    inc[1] = longint'(bus.i_evt &  bus.i_hit);
    inc[2] = longint'(bus.i_evt & !bus.i_hit);
    inc[3] = longint'(bus.d_evt & !bus.d_write);
    inc[4] = longint'(bus.d_evt &  bus.d_write);
    inc[5] = longint'(bus.d_evt &  bus.d_hit);
    inc[6] = longint'(bus.d_evt & !bus.d_hit);
    if (rst) begin
      for (int k = 0; k < 7; k++) begin n_live[k] = 0; n_snap[k] = 0; end
      n_j = -1; n_pend = 0; n_frozen = 0;
    end else begin
      for (int k = 0; k < 7; k++)
        n_live[k] = bus.clear_req ? inc[k] : sat(m_live[k] + inc[k]);
      n_snap = m_snap; n_pend = m_pend; n_frozen = m_frozen;
      if (m_j < 0) begin
        n_j = -1;
        if (bus.print_req || m_pend) begin
          n_j = 0; n_pend = 0; n_frozen = bus.clear_req;
          // print-before-clear: the job shows counts prior to this cycle
          if (bus.clear_req) n_snap = m_live;
        end
      end else begin
        if (bus.print_req) n_pend = 1;
        if (m_j == 0 && !m_frozen)
          for (int k = 0; k < 7; k++) n_snap[k] = sat(m_live[k] + inc[k]);
        n_j = (m_j == H + 1) ? -1 : m_j + 1;
      end
    end
  endtask

  task automatic tick();
    model_compute();
    @(posedge clk);
    if (rst) m_valid = 1;
    m_live = n_live; m_snap = n_snap; m_j = n_j; m_pend = n_pend; m_frozen = n_frozen;
    #1;
    if (bus.print === 1'b1 && prev_print !== 1'b1) begin
      rises++;
      rise_vals.push_back(longint'(bus.ins_reads));
    end
    prev_print = bus.print;
  endtask

  task automatic idle_in();
    bus.i_evt = 0; bus.i_hit = 0; bus.d_evt = 0; bus.d_write = 0; bus.d_hit = 0;
    bus.clear_req = 0; bus.print_req = 0;
  endtask

  task automatic do_reset();
    idle_in(); rst = 1; tick(); rst = 0;
  endtask

  task automatic start_print();
    bit seen = 0;
    bus.print_req = 1; tick(); bus.print_req = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = (bus.print === 1'b1);
    end
    if (!seen) chk("print_timeout", 64'(bus.print), 64'd1);
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("print", 64'(bus.print), 64'(m_j >= 1 && m_j <= H));
      chk("busy",  64'(bus.busy),  64'(m_j >= 0));
      if (m_j != 0)
        for (int k = 0; k < 7; k++) chk(names[k], dsnap(k), 64'(m_snap[k]));
    end
  end

  initial begin
    int r0;
    rst4 = 1;
    bus4.i_evt = 0; bus4.i_hit = 0; bus4.d_evt = 0; bus4.d_write = 0; bus4.d_hit = 0;
    bus4.clear_req = 0; bus4.print_req = 0;

    // Basic counting and print latency
    do_reset();
    chk("rst_print", 64'(bus.print), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_ins_reads", 64'(bus.ins_reads), 64'd0);
    bus.i_evt = 1; bus.i_hit = 1; repeat (3) tick();
    idle_in(); bus.d_evt = 1; bus.d_write = 1; repeat (2) tick();
    idle_in(); bus.print_req = 1; tick(); bus.print_req = 0;
    chk("lat_snap_cycle", 64'(bus.print), 64'd0);
    tick();
    chk("lat_rise", 64'(bus.print), 64'd1);
    chk7("basic", 3, 3, 0, 0, 2, 0, 2);
    tick(); chk("hold_2nd", 64'(bus.print), 64'd1);
    tick(); chk("gap_print", 64'(bus.print), 64'd0); chk("gap_busy", 64'(bus.busy), 64'd1);
    tick(); chk("idle_busy", 64'(bus.busy), 64'd0);

    // Simultaneous instruction and data events
    do_reset();
    bus.i_evt = 1; bus.d_evt = 1; repeat (4) tick();
    idle_in(); start_print();
    chk7("both", 4, 0, 4, 4, 0, 0, 4);
    repeat (3) tick();

    // Requests merged while busy
    do_reset();
    rises = 0; rise_vals.delete();
    bus.i_evt = 1; bus.i_hit = 1; tick();
    idle_in(); bus.print_req = 1; tick();
    bus.print_req = 0; tick();
    bus.print_req = 1; bus.i_evt = 1; bus.i_hit = 1; repeat (2) tick();
    idle_in(); repeat (8) tick();
    chk("pend_pulses", 64'(rises), 64'd2);
    if (rise_vals.size() == 2) begin
      chk("pend_first_ins_reads", 64'(rise_vals[0]), 64'd1);
      chk("pend_second_ins_reads", 64'(rise_vals[1]), 64'd3);
    end

    // Clear with a same-cycle data read hit
    do_reset();
    bus.i_evt = 1; repeat (2) tick();
    idle_in(); bus.clear_req = 1; bus.d_evt = 1; bus.d_hit = 1; tick();
    idle_in(); start_print();
    chk7("clr", 0, 0, 0, 1, 0, 1, 0);
    repeat (3) tick();

    // Print and clear together: print shows pre-clear counts
    do_reset();
    bus.i_evt = 1; bus.i_hit = 1; repeat (2) tick();
    bus.print_req = 1; bus.clear_req = 1; tick();
    idle_in(); tick();
    chk("pc_print", 64'(bus.print), 64'd1);
    chk("pc_ins_reads", 64'(bus.ins_reads), 64'd2);
    repeat (3) tick();
    start_print();
    chk("pc_after_ins_reads", 64'(bus.ins_reads), 64'd1);
    repeat (3) tick();

    // Reset in the first print cycle with a print pending
    do_reset();
    bus.i_evt = 1; tick();
    idle_in(); bus.print_req = 1; repeat (2) tick();
    chk("rp_pre_print", 64'(bus.print), 64'd1);
    bus.print_req = 0; rst = 1; tick(); rst = 0;
    chk("rp_print", 64'(bus.print), 64'd0);
    chk("rp_busy", 64'(bus.busy), 64'd0);
    chk7("rp", 0, 0, 0, 0, 0, 0, 0);
    r0 = rises;
    repeat (10) tick();
    chk("rp_no_pulse", 64'(rises), 64'(r0));

    // Saturation on a 4-bit instance
    rst4 = 1; tick(); rst4 = 0;
    bus4.i_evt = 1; bus4.i_hit = 1; repeat (20) tick();
    bus4.i_evt = 0; bus4.i_hit = 0; bus4.print_req = 1; tick();
    bus4.print_req = 0; tick();
    chk("sat_print", 64'(bus4.print), 64'd1);
    chk("sat_ins_reads", 64'(bus4.ins_reads), 64'd15);
    chk("sat_ins_hit", 64'(bus4.ins_hit), 64'd15);
    chk("sat_ins_miss", 64'(bus4.ins_miss), 64'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 299) == 0);
      bus.i_evt     = 1'($urandom_range(0, 1));
      bus.i_hit     = 1'($urandom_range(0, 1));
      bus.d_evt     = 1'($urandom_range(0, 1));
      bus.d_write   = 1'($urandom_range(0, 1));
      bus.d_hit     = 1'($urandom_range(0, 1));
      bus.print_req = ($urandom_range(0, 7) == 0);
      bus.clear_req = ($urandom_range(0, 15) == 0);
      tick();
    end
    rst = 0; idle_in(); repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/stats_sequencer.md
STATS_SEQUENCER -- requirements
Module: stats_sequencer

Interface
REQ-001 Parameter CNT_W, default 32, counter and snapshot width in bits.
REQ-002 Parameter PRINT_HOLD, default 2, number of cycles print is held high (legal range 1..15).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 i_evt  input  1  instruction-cache access completed this cycle.
REQ-006 i_hit  input  1  qualifies i_evt: 1 = hit, 0 = miss.
REQ-007 d_evt  input  1  data-cache access completed this cycle.
REQ-008 d_write  input  1  qualifies d_evt: 1 = write, 0 = read.
REQ-009 d_hit  input  1  qualifies d_evt: 1 = hit, 0 = miss.
REQ-010 clear_req  input  1  one-cycle request to zero all counters (trace mode 8).
REQ-011 print_req  input  1  one-cycle request to publish a statistics print (trace mode 9).
REQ-012 ins_reads, ins_hit, ins_miss, data_reads, data_writes, data_hit, data_miss  output  CNT_W each  snapshot values driven to the statistics print block.
REQ-013 print  output  1  print strobe to the statistics print block.
REQ-014 busy  output  1  high while the sequencer is in any state other than IDLE.

Function
REQ-015 Seven live counters SHALL be kept: ins_reads, ins_hit, ins_miss, data_reads, data_writes, data_hit, data_miss.
REQ-016 i_evt SHALL add 1 to ins_reads, plus ins_hit if i_hit, else ins_miss.
REQ-017 d_evt SHALL add 1 to data_writes if d_write, else data_reads, plus data_hit if d_hit, else data_miss.
REQ-018 i_evt and d_evt in the same cycle SHALL both be counted; no event is ever dropped, except by saturation.
REQ-019 Each counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 Counters SHALL update in every state, including during a print.
REQ-021 Outputs SHALL be snapshot registers, loaded only in SNAP; they are stable while print is high.
REQ-022 FSM states: IDLE, SNAP, PRINT, GAP.
REQ-023 IDLE -> SNAP on print_req (or a pending print); otherwise stay in IDLE.
REQ-024 SNAP, one cycle: load all snapshots from live counters including same-cycle events; -> PRINT.
REQ-025 PRINT: print=1 for exactly PRINT_HOLD cycles, then -> GAP.
REQ-026 GAP, one cycle: print=0; -> IDLE, so that back-to-back prints give distinct rising edges.
REQ-027 Latency: print rises 2 cycles after the cycle in which print_req is sampled in IDLE.
REQ-028 print_req while busy SHALL set a single pending flag; further requests while pending is set are merged; pending is consumed on the next IDLE -> SNAP.
REQ-029 clear_req SHALL zero live counters at the next edge; same-cycle events are then applied on top, leaving results of 0 or 1.
REQ-030 clear_req SHALL NOT alter the snapshots or the FSM; a print in progress completes with the pre-clear values.
REQ-031 Simultaneous print_req and clear_req in IDLE: the snapshot takes pre-clear values (print before clear), and the live counters clear in that same edge.

Reset
REQ-032 reset SHALL force the FSM to IDLE and zero all live counters, all snapshots and the pending flag; print=0 and busy=0 on the cycle after reset.
REQ-033 reset SHALL take priority over all inputs, including mid-PRINT; print drops on the next edge and no pending print survives.

Verification
REQ-034 After reset, 3 cycles of i_evt/i_hit=1 and 2 cycles of d_evt/d_write=1/d_hit=0, then print_req -> print high 2 cycles starting 2 cycles later; ins_reads=3, ins_hit=3, data_writes=2, data_miss=2, all others 0.
REQ-035 i_evt and d_evt together for 4 cycles with all qualifiers 0 -> ins_reads=4, ins_miss=4, data_reads=4, data_miss=4.
REQ-036 print_req twice during PRINT -> exactly two print pulses separated by at least 1 low cycle; the second snapshot includes events counted during the first print.
REQ-037 clear_req with a same-cycle d_evt/d_hit=1 read, then print -> data_reads=1, data_hit=1, all others 0.
REQ-038 With CNT_W=4, 20 i_hit events -> ins_reads=15 and ins_hit=15 (saturated).
REQ-039 reset asserted during the first PRINT cycle, with a print pending -> print=0, busy=0, all outputs 0 on the next cycle, and no further print pulse.
